// File: rtl/membus_arbiter_pkg.sv
// membus_arbiter_pkg: shared state encoding, target/direction codes and timing defaults
package membus_arbiter_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_RECOVER} state_t;
    localparam logic dev_REG = 1'b0;
    localparam logic dev_MEM = 1'b1;
    localparam logic mode_READ = 1'b0;
    localparam logic mode_WRITE = 1'b1;
    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd64;
    localparam logic [3:0] RECOVER_DEFAULT = 4'd8;
endpackage

// File: rtl/membus_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the requester not served last wins a tie
module rr_arbiter2 (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] grant
);
    logic last;
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) last <= 1'b1;
        else if (update) last <= served;
    end
    always_comb grant = (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/membus_arbiter.sv
// membus_arbiter: two-requester arbiter driving a toggle-strobed register/memory bus with timeout recovery
module membus_arbiter
    import membus_arbiter_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [3:0] RECOVER_CYCLES = RECOVER_DEFAULT
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_regmem0,
    input  logic        i_regmem1,
    input  logic        i_rw0,
    input  logic        i_rw1,
    input  logic [15:0] i_address0,
    input  logic [15:0] i_address1,
    input  logic [7:0]  i_wdata0,
    input  logic [7:0]  i_wdata1,
    output logic        o_ack0,
    output logic        o_ack1,
    output logic        o_err0,
    output logic        o_err1,
    output logic [7:0]  o_rdata0,
    output logic [7:0]  o_rdata1,
    output logic        o_apulse,
    output logic        o_regmem,
    output logic        o_rw,
    output logic [15:0] o_address,
    output logic [7:0]  o_byte,
    input  logic [7:0]  i_byte,
    input  logic        i_ready,
    output logic [1:0]  o_grant,
    output logic        o_busy
);
    state_t     state;
    logic       own, busy, apulse, upd;
    logic [1:0] win, ack, err;
    logic [7:0] rdata [2];
    logic [7:0] tcnt;
    logic [3:0] rcnt;
    assign upd = state == S_DONE || (state == S_RECOVER && rcnt == RECOVER_CYCLES - 4'd1);
    rr_arbiter2 u_rr (
        .i_sys_clk(i_sys_clk),
        .i_sys_rst(i_sys_rst),
        .req({i_req1, i_req0}),
        .update(upd),
        .served(own),
        .grant(win)
    );
    // apulse is deliberately outside the reset branch so reset never makes a downstream edge
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state <= S_IDLE;
            own <= 1'b0;
            busy <= 1'b0;
            o_grant <= 2'b00;
            ack <= 2'b00;
            err <= 2'b00;
            rdata[0] <= 8'h00;
            rdata[1] <= 8'h00;
            tcnt <= 8'h00;
            rcnt <= 4'h0;
            {o_regmem, o_rw, o_address, o_byte} <= '0;
        end else begin
            case (state)
                S_IDLE: if (|win) begin
                    own <= win[1];
                    o_grant <= win;
                    busy <= 1'b1;
                    {o_regmem, o_rw, o_address, o_byte} <= win[1] ?
                        {i_regmem1, i_rw1, i_address1, i_wdata1} : {i_regmem0, i_rw0, i_address0, i_wdata0};
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    apulse <= ~apulse;
                    tcnt <= 8'h00;
                    state <= S_WAIT;
                end
                S_WAIT: if (i_ready) begin
                    ack[own] <= 1'b1;
                    if (o_rw == mode_READ) rdata[own] <= i_byte;
                    state <= S_DONE;
                end else if (tcnt + 8'd1 == TIMEOUT_CYCLES) begin
                    ack[own] <= 1'b1;
                    err[own] <= 1'b1;
                    rdata[own] <= 8'h00;
                    tcnt <= tcnt + 8'd1;
                    rcnt <= 4'h0;
                    state <= S_RECOVER;
                end else begin
                    tcnt <= tcnt + 8'd1;
                end
                S_DONE: begin
                    ack <= 2'b00;
                    err <= 2'b00;
                    o_grant <= 2'b00;
                    busy <= 1'b0;
                    state <= S_IDLE;
                end
                S_RECOVER: begin
                    ack <= 2'b00;
                    err <= 2'b00;
                    o_grant <= 2'b00;
                    rcnt <= rcnt + 4'd1;
                    if (rcnt == RECOVER_CYCLES - 4'd1) begin
                        busy <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    assign o_apulse = apulse;
    assign o_busy = busy;
    assign {o_ack1, o_ack0} = ack;
    assign {o_err1, o_err0} = err;
    assign o_rdata0 = rdata[0];
    assign o_rdata1 = rdata[1];
endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter: directed checks of membus_arbiter against a toggle-strobed register/memory target
module tb_membus_arbiter;
    logic        i_sys_clk, i_sys_rst;
    logic        i_req0, i_req1, i_regmem0, i_regmem1, i_rw0, i_rw1;
    logic [15:0] i_address0, i_address1;
    logic [7:0]  i_wdata0, i_wdata1;
    logic        o_ack0, o_ack1, o_err0, o_err1;
    logic [7:0]  o_rdata0, o_rdata1;
    logic        o_apulse, o_regmem, o_rw;
    logic [15:0] o_address;
    logic [7:0]  o_byte, i_byte;
    logic        i_ready, resp_rdy, late_rdy, tgt_en;
    logic [1:0]  o_grant;
    logic        o_busy;
    int tests, fails, cyc, edges, issue_cyc, acks0, acks1, hold_bad, both_ack;
    assign i_ready = resp_rdy | late_rdy;
    membus_arbiter dut (
        .i_sys_clk(i_sys_clk), .i_sys_rst(i_sys_rst),
        .i_req0(i_req0), .i_req1(i_req1), .i_regmem0(i_regmem0), .i_regmem1(i_regmem1),
        .i_rw0(i_rw0), .i_rw1(i_rw1), .i_address0(i_address0), .i_address1(i_address1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1), .o_ack0(o_ack0), .o_ack1(o_ack1),
        .o_err0(o_err0), .o_err1(o_err1), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .o_apulse(o_apulse), .o_regmem(o_regmem), .o_rw(o_rw), .o_address(o_address),
        .o_byte(o_byte), .i_byte(i_byte), .i_ready(i_ready), .o_grant(o_grant), .o_busy(o_busy)
    );
    initial begin
        i_sys_clk = 1'b0;
        forever #5 i_sys_clk = ~i_sys_clk;
    end
    initial begin
        cyc = 0;
        forever @(posedge i_sys_clk) cyc++;
    end
    // target: answers each apulse edge with a one-cycle ready four WAIT cycles later
    initial begin
        logic [7:0]  mem [65536];
        logic [15:0] digit;
        logic [25:0] lat_op;
        logic        ap_q;
        int          cd;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        digit = 16'h3C5A;
        ap_q = 1'b0; cd = 0; edges = 0; issue_cyc = 0; acks0 = 0; acks1 = 0;
        hold_bad = 0; both_ack = 0; resp_rdy = 1'b0; i_byte = 8'h00; lat_op = '0;
        forever begin
            @(negedge i_sys_clk);
            resp_rdy = 1'b0;
            if (cd != 0) begin
                cd--;
                if (cd == 0 && tgt_en) begin
                    if (o_busy && {o_regmem, o_rw, o_address, o_byte} !== lat_op) hold_bad++;
                    resp_rdy = 1'b1;
                    if (lat_op[24]) begin
                        if (lat_op[25]) mem[lat_op[23:8]] = lat_op[7:0];
                        else if (lat_op[8]) digit[15:8] = lat_op[7:0];
                        else digit[7:0] = lat_op[7:0];
                    end else begin
                        i_byte = lat_op[25] ? mem[lat_op[23:8]] : (lat_op[8] ? digit[15:8] : digit[7:0]);
                    end
                end
            end
            if (o_apulse !== ap_q) begin
                edges++;
                issue_cyc = cyc;
                cd = 3;
                lat_op = {o_regmem, o_rw, o_address, o_byte};
            end
            ap_q = o_apulse;
            if (o_ack0) acks0++;
            if (o_ack1) acks1++;
            if (o_ack0 && o_ack1) both_ack++;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge i_sys_clk);
    endtask
    task automatic wait_ack(input string tag, input int budget, output int who, output int lat);
        int n = 0;
        while (!(o_ack0 || o_ack1) && n < budget) begin
            @(negedge i_sys_clk);
            n++;
        end
        chk(tag, 32'(n < budget), 1);
        who = o_ack1 ? 1 : 0;
        lat = cyc - issue_cyc;
    endtask
    initial begin
        int who, lat, e0, a0, a1, rec;
        logic ap;
        tests = 0; fails = 0; late_rdy = 1'b0; tgt_en = 1'b1; i_sys_rst = 1'b1;
        {i_req0, i_req1, i_regmem0, i_regmem1, i_rw0, i_rw1} = '0;
        {i_address0, i_address1, i_wdata0, i_wdata1} = '0;
        tick(3);
        chk("rst_grant", o_grant, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ack", {o_ack1, o_ack0, o_err1, o_err0}, 0);
        chk("rst_rdata", {o_rdata1, o_rdata0}, 0);
        chk("rst_bus", {o_regmem, o_rw, o_address, o_byte}, 0);
        chk("rst_apulse", o_apulse, 0);
        i_sys_rst = 1'b0;
        tick(1);
        // memory write then read-back by requester 0
        {i_regmem0, i_rw0, i_address0, i_wdata0} = {1'b1, 1'b1, 16'h4910, 8'hA5};
        i_req0 = 1'b1; e0 = edges;
        wait_ack("wr_ack", 100, who, lat);
        chk("wr_who", who, 0);
        chk("wr_err", o_err0, 0);
        chk("wr_lat", lat, 4);
        chk("wr_edges", edges - e0, 1);
        chk("wr_grant", o_grant, 2'b01);
        chk("wr_busy", o_busy, 1);
        i_req0 = 1'b0;
        tick(1);
        chk("wr_ack_len", o_ack0, 0);
        chk("done_grant", o_grant, 0);
        chk("done_busy", o_busy, 0);
        i_rw0 = 1'b0; i_req0 = 1'b1;
        wait_ack("rd_ack", 100, who, lat);
        chk("rd_who", who, 0);
        chk("rd_data", o_rdata0, 8'hA5);
        chk("rd_err", o_err0, 0);
        i_req0 = 1'b0;
        tick(1);
        // register read, upper byte selected by address bit 0
        {i_regmem1, i_rw1, i_address1} = {1'b0, 1'b0, 16'h4901};
        i_req1 = 1'b1;
        wait_ack("reg_ack", 100, who, lat);
        chk("reg_who", who, 1);
        chk("reg_data", o_rdata1, 8'h3C);
        chk("reg_err", o_err1, 0);
        i_req1 = 1'b0;
        tick(1);
        // simultaneous requests held high alternate 0,1,0,1
        {i_regmem0, i_rw0, i_address0} = {1'b0, 1'b0, 16'h4900};
        i_req0 = 1'b1; i_req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e0 = edges;
            wait_ack("rr_ack", 100, who, lat);
            chk("rr_who", who, k % 2);
            chk("rr_edges", edges - e0, 1);
            if (k == 0) chk("rr_data0", o_rdata0, 8'h5A);
            if (k == 3) begin i_req0 = 1'b0; i_req1 = 1'b0; end
            tick(1);
        end
        // requester 0 drops on ack while requester 1 holds
        i_req0 = 1'b1; i_req1 = 1'b1;
        wait_ack("drop_ack0", 100, who, lat);
        chk("drop_who0", who, 0);
        i_req0 = 1'b0;
        tick(1);
        a0 = acks0;
        wait_ack("drop_ack1", 100, who, lat);
        chk("drop_who1", who, 1);
        i_req1 = 1'b0;
        tick(10);
        chk("drop_no_reserve", acks0 - a0, 0);
        chk("drop_idle", o_busy, 0);
        // timeout with a silent target, late ready during recovery and in idle
        tgt_en = 1'b0;
        {i_regmem0, i_rw0, i_address0} = {1'b1, 1'b0, 16'h4910};
        i_req0 = 1'b1;
        wait_ack("to_ack", 200, who, lat);
        chk("to_who", who, 0);
        chk("to_err", o_err0, 1);
        chk("to_rdata", o_rdata0, 8'h00);
        chk("to_lat", lat, 64);
        i_req0 = 1'b0;
        rec = 0; a0 = 0; a1 = 0;
        while (o_busy && rec < 50) begin
            late_rdy = (rec == 2);
            tick(1);
            rec++;
            if (rec == 1) begin a0 = acks0; a1 = acks1; chk("to_ack_len", o_ack0, 0); end
        end
        late_rdy = 1'b0;
        chk("to_recover_len", rec, 8);
        late_rdy = 1'b1;
        tick(1);
        late_rdy = 1'b0;
        tick(3);
        chk("late_no_ack", (acks0 - a0) + (acks1 - a1), 0);
        chk("late_idle", o_busy, 0);
        tgt_en = 1'b1;
        // reset during WAIT aborts silently and leaves apulse alone
        {i_regmem1, i_rw1, i_address1, i_wdata1} = {1'b1, 1'b1, 16'h1234, 8'h5A};
        i_req1 = 1'b1; e0 = edges; rec = 0;
        while (edges == e0 && rec < 20) begin tick(1); rec++; end
        chk("rst_issue", edges - e0, 1);
        tick(1);
        ap = o_apulse; i_sys_rst = 1'b1; i_req1 = 1'b0;
        tick(1);
        i_sys_rst = 1'b0;
        chk("rstw_apulse", o_apulse, ap);
        chk("rstw_state", {o_busy, o_grant, o_ack1, o_ack0}, 0);
        a0 = acks0; a1 = acks1;
        tick(6);
        chk("rstw_no_ack", (acks0 - a0) + (acks1 - a1), 0);
        chk("rstw_no_edge", edges - e0, 1);
        {i_regmem1, i_rw1, i_address1} = {1'b1, 1'b0, 16'h4910};
        i_req1 = 1'b1;
        wait_ack("post_ack", 100, who, lat);
        chk("post_who", who, 1);
        chk("post_err", o_err1, 0);
        chk("post_data", o_rdata1, 8'hA5);
        chk("post_lat", lat, 4);
        i_req1 = 1'b0;
        tick(2);
        chk("bus_hold", hold_bad, 0);
        chk("dual_ack", both_ack, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
